// File: rtl/scramble_pkg.sv
// Shared constants, FSM state type and LFSR step for the scramble random server.
// Optional feature macro used by this slice: SCRAMBLE_SEED_LOAD_EN.
package scramble_pkg;

    localparam int          LfsrWidth   = 16;
    localparam logic [15:0] TapMask     = 16'hB400;
    localparam logic [15:0] DefaultSeed = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        DONE
    } stateT;

    // One Galois step of x^16+x^14+x^13+x^11+1 (right shift, feed back lsb)
    function automatic logic [LfsrWidth-1:0] lfsrNext(
        input logic [LfsrWidth-1:0] v
    );
        return (v >> 1) ^ (v[0] ? TapMask : '0);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR with reload port and all-zero lockup guard.
// A zero load value falls back to the seed so the register never locks up.
module lfsr16
    import scramble_pkg::*;
#(
    parameter logic [LfsrWidth-1:0] SeedVal = DefaultSeed
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [LfsrWidth-1:0] load_val,
    output logic [LfsrWidth-1:0] q
);

    // Reload beats lockup guard; otherwise advance every cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= SeedVal;
        end else if (load) begin
            q <= (load_val == '0) ? SeedVal : load_val;
        end else if (q == '0) begin
            q <= SeedVal;
        end else begin
            q <= lfsrNext(q);
        end
    end

endmodule

// File: rtl/scramble_rand_server.sv
// Serves one bounded pseudo-random index per rising edge of RandomPlease.
// Define SCRAMBLE_SEED_LOAD_EN to add the SeedIn/SeedLoad reseed ports.
module scramble_rand_server
    import scramble_pkg::*;
#(
    parameter int          RandNum  = 31,
    parameter int          MaxTries = 4,
    parameter logic [15:0] SeedVal  = DefaultSeed,
    localparam int         W        = $clog2(RandNum + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         RandomPlease,
`ifdef SCRAMBLE_SEED_LOAD_EN
    input  logic [15:0]  SeedIn,
    input  logic         SeedLoad,
`endif
    output logic [W-1:0] RandOut,
    output logic         RandValid,
    output logic         Busy
);

    localparam logic [W-1:0] MaxIdx  = W'(RandNum);
    localparam logic [W-1:0] Span    = W'(RandNum + 1);
    localparam logic [3:0]   LastTry = 4'(MaxTries - 1);

    logic [LfsrWidth-1:0] lfsrQ;
    logic                 lfsrLoad;
    logic [LfsrWidth-1:0] lfsrLoadVal;
    logic                 reqQ;
    logic                 reqRise;
    stateT                state;
    logic [3:0]           tries;
    logic [W-1:0]         cand;
    logic                 inRange;
    logic [W-1:0]         folded;

`ifdef SCRAMBLE_SEED_LOAD_EN
    assign lfsrLoad    = SeedLoad;
    assign lfsrLoadVal = SeedIn;
`else
    assign lfsrLoad    = 1'b0;
    assign lfsrLoadVal = SeedVal;
`endif

    lfsr16 #(
        .SeedVal (SeedVal)
    ) uLfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lfsrLoad),
        .load_val (lfsrLoadVal),
        .q        (lfsrQ)
    );

    assign reqRise = RandomPlease & ~reqQ;
    assign cand    = W'(lfsrQ);
    assign inRange = (cand <= MaxIdx);
    assign folded  = cand - Span;

    // Track the request level every cycle so held requests fire once
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reqQ <= 1'b0;
        end else begin
            reqQ <= RandomPlease;
        end
    end

    // Draw FSM: accept in-range sample, or fold after the last rejected try
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            RandOut   <= '0;
            RandValid <= 1'b0;
            Busy      <= 1'b0;
            tries     <= '0;
        end else begin
            RandValid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (reqRise) begin
                        state <= SAMPLE;
                        Busy  <= 1'b1;
                        tries <= '0;
                    end
                end
                SAMPLE: begin
                    if (inRange) begin
                        RandOut   <= cand;
                        RandValid <= 1'b1;
                        state     <= DONE;
                    end else if (tries == LastTry) begin
                        RandOut   <= folded;
                        RandValid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        tries <= tries + 4'd1;
                    end
                end
                DONE: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scramble_rand_server.sv
// Directed bench for scramble_rand_server: cycle table plus bounded-draw sweep.
// Seed-load checks are compiled in when SCRAMBLE_SEED_LOAD_EN is defined.
module tb_scramble_rand_server;

    localparam logic [15:0] Seed = 16'hACE1;

    typedef struct {
        logic rstN;
        logic req;
        logic smp;
        logic expV;
        logic expB;
    } rowT;

    logic        clk = 1'b0;
    logic        rstN;
    logic        reqA;
    logic        reqB;
    logic [4:0]  outA;
    logic [4:0]  outB;
    logic        validA;
    logic        validB;
    logic        busyA;
    logic        busyB;
    logic [15:0] gold;
    logic [15:0] lfsrA;
`ifdef SCRAMBLE_SEED_LOAD_EN
    logic [15:0] seedIn;
    logic        seedLoad;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scramble_rand_server dutA (
        .clk          (clk),
        .rst_n        (rstN),
        .RandomPlease (reqA),
`ifdef SCRAMBLE_SEED_LOAD_EN
        .SeedIn       (seedIn),
        .SeedLoad     (seedLoad),
`endif
        .RandOut      (outA),
        .RandValid    (validA),
        .Busy         (busyA)
    );

    scramble_rand_server #(
        .RandNum  (20),
        .MaxTries (4)
    ) dutB (
        .clk          (clk),
        .rst_n        (rstN),
        .RandomPlease (reqB),
`ifdef SCRAMBLE_SEED_LOAD_EN
        .SeedIn       (seedIn),
        .SeedLoad     (seedLoad),
`endif
        .RandOut      (outB),
        .RandValid    (validB),
        .Busy         (busyB)
    );

    assign lfsrA = dutA.uLfsr.q;

    function automatic logic [15:0] gnext(input logic [15:0] v);
        logic [15:0] n;
        n = {1'b0, v[15:1]};
        if (v[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    // Golden LFSR trace, shared by both instances
    always @(posedge clk) begin
        if (!rstN) gold <= Seed;
`ifdef SCRAMBLE_SEED_LOAD_EN
        else if (seedLoad) gold <= (seedIn == 16'h0) ? Seed : seedIn;
`endif
        else gold <= gnext(gold);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    rowT        rows[22];
    logic [4:0] pend;
    logic [4:0] expOut;
    logic       prevRst;
    bit         seen[21];
    int         nSeen;

    initial begin
        rows[0]  = '{1, 1, 0, 0, 0};
        rows[1]  = '{1, 0, 1, 0, 1};
        rows[2]  = '{1, 0, 0, 1, 1};
        rows[3]  = '{1, 0, 0, 0, 0};
        rows[4]  = '{1, 1, 0, 0, 0};
        rows[5]  = '{1, 1, 1, 0, 1};
        rows[6]  = '{1, 1, 0, 1, 1};
        rows[7]  = '{1, 1, 0, 0, 0};
        rows[8]  = '{1, 1, 0, 0, 0};
        rows[9]  = '{1, 1, 0, 0, 0};
        rows[10] = '{1, 1, 0, 0, 0};
        rows[11] = '{1, 1, 0, 0, 0};
        rows[12] = '{1, 0, 0, 0, 0};
        rows[13] = '{1, 1, 0, 0, 0};
        rows[14] = '{1, 0, 1, 0, 1};
        rows[15] = '{1, 1, 0, 1, 1};
        rows[16] = '{1, 1, 0, 0, 0};
        rows[17] = '{1, 0, 0, 0, 0};
        rows[18] = '{1, 1, 0, 0, 0};
        rows[19] = '{0, 1, 1, 0, 1};
        rows[20] = '{1, 0, 0, 0, 0};
        rows[21] = '{1, 0, 0, 0, 0};

        rstN = 1'b0;
        reqA = 1'b0;
        reqB = 1'b0;
`ifdef SCRAMBLE_SEED_LOAD_EN
        seedIn   = 16'h0;
        seedLoad = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rstOut", outA, 0);
        chk("rstValid", validA, 0);
        chk("rstBusy", busyA, 0);
        chk("rstLfsr", lfsrA, Seed);
        rstN = 1'b1;

        @(negedge clk);
        chk("lfsrStep1", lfsrA, 16'hE270);
        for (int i = 0; i < 20; i++) begin
            chk("idleValid", validA, 0);
            chk("idleBusy", busyA, 0);
            chk("idleOut", outA, 0);
            chk("idleLfsr", lfsrA, gold);
            @(negedge clk);
        end

        expOut  = 5'd0;
        pend    = 5'd0;
        prevRst = 1'b0;
        for (int i = 0; i < 22; i++) begin
            if (rows[i].smp) pend = gold[4:0];
            if (rows[i].expV) expOut = pend;
            chk($sformatf("row%0dValid", i), validA, rows[i].expV);
            chk($sformatf("row%0dBusy", i), busyA, rows[i].expB);
            chk($sformatf("row%0dOut", i), outA, expOut);
            chk($sformatf("row%0dLfsr", i), lfsrA, gold);
            if (prevRst) chk("postRstLfsr", lfsrA, Seed);
            rstN    = rows[i].rstN;
            reqA    = rows[i].req;
            prevRst = !rows[i].rstN;
            if (!rows[i].rstN) expOut = 5'd0;
            @(negedge clk);
        end

        for (int n = 0; n < 1000; n++) begin
            int  tries;
            int  expLat;
            int  expVal;
            int  lat;
            int  val;
            bit  predicted;
            bit  got;
            int  cand;
            tries     = 0;
            expLat    = 0;
            expVal    = 0;
            lat       = 0;
            val       = 0;
            predicted = 0;
            got       = 0;
            reqB      = 1'b1;
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                if (!predicted) begin
                    cand = int'(gold[4:0]);
                    if (cand <= 20) begin
                        expVal    = cand;
                        expLat    = k + 1;
                        predicted = 1;
                    end else if (tries == 3) begin
                        expVal    = cand - 21;
                        expLat    = k + 1;
                        predicted = 1;
                    end else begin
                        tries++;
                    end
                end
                if (validB) begin
                    got = 1;
                    lat = k;
                    val = int'(outB);
                    break;
                end
            end
            chk("drawTimeout", got, 1);
            chk("drawLat", lat, expLat);
            chk("drawLatRange", (lat >= 2 && lat <= 5), 1);
            chk("drawRange", (val <= 20), 1);
            chk("drawVal", val, expVal);
            if (val >= 0 && val <= 20) seen[val] = 1'b1;
            reqB = 1'b0;
            @(negedge clk);
        end
        nSeen = 0;
        for (int v = 0; v < 21; v++) if (seen[v]) nSeen++;
        chk("allValues", nSeen, 21);

`ifdef SCRAMBLE_SEED_LOAD_EN
        seedLoad = 1'b1;
        seedIn   = 16'h0;
        @(negedge clk);
        chk("seedZero", lfsrA, Seed);
        seedIn = 16'h1234;
        @(negedge clk);
        chk("seedLoad", lfsrA, 16'h1234);
        seedLoad = 1'b0;
        @(negedge clk);
        chk("seedAdvance", lfsrA, gold);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
